// File: rtl/s4ga_pkg.sv
// Shared geometry helpers and state type for the s4ga configuration stream.
// Used by the streamer RTL and by the bench's config model.
package s4ga_pkg;

  typedef enum logic [1:0] {IDLE, RESET, STREAM} state_t;

  function automatic int ceil_div(input int a, input int b);
    return (a + b - 1) / b;
  endfunction

  function automatic int n_w(input int n);
    return $clog2(n);
  endfunction

  function automatic int idx_segs(input int n, input int si_w);
    return ceil_div(n_w(n), si_w);
  endfunction

  function automatic int mask_segs(input int k, input int si_w);
    return ceil_div(1 << k, si_w);
  endfunction

  function automatic int lut_segs(input int n, input int k, input int si_w);
    return k * idx_segs(n, si_w) + mask_segs(k, si_w);
  endfunction

  function automatic int total_segs(input int n, input int k, input int si_w);
    return n * lut_segs(n, k, si_w);
  endfunction

  function automatic int seg_aw(input int n, input int k, input int si_w);
    return $clog2(total_segs(n, k, si_w));
  endfunction

endpackage

// File: rtl/s4ga_cfg_mem.sv
// Config segment store: one write port, one registered read port (read-before-write).
// The read register clears when not enabled so it can directly drive the fabric's si.
module s4ga_cfg_mem #(
  parameter int DEPTH = 1422,
  parameter int W     = 4,
  parameter int AW    = 11
) (
  input  logic          clk,
  input  logic          rst_ni,
  input  logic          we_i,
  input  logic [AW-1:0] waddr_i,
  input  logic [W-1:0]  wdata_i,
  input  logic          rd_en_i,
  input  logic [AW-1:0] raddr_i,
  output logic [W-1:0]  rdata_o
);

  logic [W-1:0] mem_q [DEPTH];

  // Out-of-range writes are discarded rather than aliased.
  always_ff @(posedge clk) begin
    if (we_i && (int'(waddr_i) < DEPTH)) mem_q[waddr_i] <= wdata_i;
  end

  always_ff @(posedge clk or negedge rst_ni) begin
    if (!rst_ni)      rdata_o <= '0;
    else if (rd_en_i) rdata_o <= mem_q[raddr_i];
    else              rdata_o <= '0;
  end

endmodule

// File: rtl/s4ga_cfg_streamer.sv
// Transmit end of the s4ga config stream: holds fabric reset, then replays all
// config segments back-to-back forever, counting frames until asked to stop.
module s4ga_cfg_streamer
  import s4ga_pkg::*;
#(
  parameter int N          = 79,
  parameter int K          = 5,
  parameter int SI_W       = 4,
  parameter int RST_CYCLES = N + 2,
  parameter int FCNT_W     = 16,
  localparam int TOTAL_SEGS = total_segs(N, K, SI_W),
  localparam int SEG_AW     = seg_aw(N, K, SI_W)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              stop,
  input  logic              cfg_we,
  input  logic [SEG_AW-1:0] cfg_addr,
  input  logic [SI_W-1:0]   cfg_wdata,
  output logic [SI_W-1:0]   si,
  output logic              tgt_rst,
  output logic              frame_done,
  output logic [FCNT_W-1:0] frame_cnt,
  output logic              busy,
  output state_t            dbg_state
);

  localparam int RC_W = $clog2(RST_CYCLES);
  localparam logic [SEG_AW-1:0] LAST = SEG_AW'(TOTAL_SEGS - 1);

  state_t            state_q;
  logic [RC_W-1:0]   rst_cnt_q;
  logic [SEG_AW-1:0] show_q;
  logic              stop_q;
  logic              tgt_rst_q;
  logic              frame_done_q;
  logic [FCNT_W-1:0] frame_cnt_q;

  logic              rd_en;
  logic [SEG_AW-1:0] rd_addr;
  logic              rst_last;
  logic              frame_end;
  logic              leave_stream;

  // show_q is the address on si this cycle; rd_addr is the one fetched for next cycle.
  assign rst_last     = (state_q == RESET) && (rst_cnt_q == RC_W'(RST_CYCLES - 1));
  assign frame_end    = (state_q == STREAM) && (show_q == LAST);
  assign leave_stream = frame_end && (stop_q || stop);

  always_comb begin
    rd_en   = 1'b0;
    rd_addr = '0;
    case (state_q)
      RESET:   rd_en = rst_last && !stop;
      STREAM: begin
        rd_en   = !leave_stream;
        rd_addr = frame_end ? '0 : show_q + 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      rst_cnt_q    <= '0;
      show_q       <= '0;
      stop_q       <= 1'b0;
      tgt_rst_q    <= 1'b1;
      frame_done_q <= 1'b0;
      frame_cnt_q  <= '0;
    end else begin
      frame_done_q <= 1'b0;
      if (frame_done_q) frame_cnt_q <= frame_cnt_q + 1'b1;
      case (state_q)
        IDLE: begin
          tgt_rst_q <= 1'b1;
          stop_q    <= 1'b0;
          if (start) begin
            state_q   <= RESET;
            rst_cnt_q <= '0;
          end
        end
        RESET: begin
          if (stop) begin
            state_q <= IDLE;
          end else if (rst_last) begin
            state_q   <= STREAM;
            tgt_rst_q <= 1'b0;
            show_q    <= '0;
          end else begin
            rst_cnt_q <= rst_cnt_q + 1'b1;
          end
        end
        STREAM: begin
          if (stop) stop_q <= 1'b1;
          show_q       <= rd_addr;
          frame_done_q <= rd_en && (rd_addr == LAST);
          if (leave_stream) begin
            state_q   <= IDLE;
            tgt_rst_q <= 1'b1;
            stop_q    <= 1'b0;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  s4ga_cfg_mem #(
    .DEPTH (TOTAL_SEGS),
    .W     (SI_W),
    .AW    (SEG_AW)
  ) u_mem (
    .clk     (clk),
    .rst_ni  (rst_n),
    .we_i    (cfg_we),
    .waddr_i (cfg_addr),
    .wdata_i (cfg_wdata),
    .rd_en_i (rd_en),
    .raddr_i (rd_addr),
    .rdata_o (si)
  );

  assign tgt_rst    = tgt_rst_q;
  assign frame_done = frame_done_q;
  assign frame_cnt  = frame_cnt_q;
  assign busy       = (state_q != IDLE);
  assign dbg_state  = state_q;

endmodule
